// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the req/ack handshake to instruction memory and
// registers the fetched word. Defining IF_FETCH_CNT_EN adds the fetch_count output.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [5:0]  OP,
    output logic [5:0]  Funct
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] w_target;
    logic        r_req;
    logic        r_valid;
    logic        r_drop;
    logic        w_drop_nxt;
    logic        w_capture;
    logic        w_req_start;

    assign w_target = redirect_pc & 32'hFFFF_FFFC;

    // A new request starts on entering FETCH, or when an ack closes one while staying in FETCH.
    assign w_req_start = (w_state_nxt == ST_FETCH) && ((r_state != ST_FETCH) || imem_ack);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next-pc and drop tracking; redirect wins over ack and stall
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_capture   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
                w_drop_nxt  = 1'b0;
                if (redirect) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    // An unacked request cannot be cancelled, so its data must be dropped later.
                    w_pc_nxt    = w_target;
                    w_drop_nxt  = ~imem_ack;
                    w_state_nxt = ST_FETCH;
                end else if (imem_ack) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_capture   = 1'b1;
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = ST_ISSUE;
                    end
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                w_drop_nxt = 1'b0;
                if (redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_FETCH;
                end else if (stall) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_drop_nxt  = 1'b0;
            end
        endcase
    end

    // Registered datapath: pc, request address, captured instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= PC_RESET;
            r_addr     <= PC_RESET;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_drop     <= 1'b0;
            r_instr    <= 32'h0000_0000;
            r_instr_pc <= 32'h0000_0000;
        end else begin
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            r_req   <= (w_state_nxt == ST_FETCH);
            r_valid <= (w_state_nxt == ST_ISSUE);
            if (w_req_start) begin
                r_addr <= w_pc_nxt;
            end
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    // Output drive from registers; OP/Funct are slices of the instruction register
    always_comb begin
        imem_req    = r_req;
        imem_addr   = r_addr;
        instr       = r_instr;
        instr_pc    = r_instr_pc;
        instr_valid = r_valid;
        OP          = r_instr[31:26];
        Funct       = r_instr[5:0];
    end

`ifdef IF_FETCH_CNT_EN
    logic        w_consume;
    logic [31:0] r_fetch_count;

    assign w_consume   = (r_state == ST_ISSUE) && !stall && !redirect;
    assign fetch_count = r_fetch_count;

    // Consumed-instruction counter, wraps at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'd0;
        end else if (w_consume) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences for reset and
// PC wrap, then random stimulus against a transaction-level reference model.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ack, stall, redir;
    logic [31:0] rdata, rpc;
    logic        req, valid;
    logic [31:0] addr, instr, ipc;
    logic [5:0]  op, funct;

    logic        rst2_n, ack2, stall2, redir2;
    logic [31:0] rdata2, rpc2;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, ipc2;
    logic [5:0]  op2, funct2;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fcnt, fcnt2;
    logic [31:0] m_cnt;
`endif

    instr_fetch_unit u_dut (
`ifdef IF_FETCH_CNT_EN
        .fetch_count(fcnt),
`endif
        .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr),
        .imem_rdata(rdata), .imem_ack(ack), .stall(stall), .redirect(redir),
        .redirect_pc(rpc), .instr(instr), .instr_pc(ipc), .instr_valid(valid),
        .OP(op), .Funct(funct)
    );

    instr_fetch_unit #(.PC_RESET(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_dut_wrap (
`ifdef IF_FETCH_CNT_EN
        .fetch_count(fcnt2),
`endif
        .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .imem_ack(ack2), .stall(stall2), .redirect(redir2),
        .redirect_pc(rpc2), .instr(instr2), .instr_pc(ipc2), .instr_valid(valid2),
        .OP(op2), .Funct(funct2)
    );

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic [31:0] d, input logic s,
                                input logic r, input logic [31:0] p, input logic er,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] en);
        vec_t v;
        v.ack = a; v.rdata = d; v.stall = s; v.redir = r; v.rpc = p;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_ipc = ei; v.e_instr = en;
        return v;
    endfunction

    // Reference model: fetch phase is implied by which of req/valid is up
    logic [31:0] m_pc, m_addr, m_instr, m_ipc;
    logic        m_req, m_valid, m_drop;

    task automatic model_reset();
        m_pc = 32'h0000_0000; m_addr = 32'h0000_0000; m_instr = 32'h0000_0000;
        m_ipc = 32'h0000_0000; m_req = 1'b0; m_valid = 1'b0; m_drop = 1'b0;
`ifdef IF_FETCH_CNT_EN
        m_cnt = 32'd0;
`endif
    endtask

    task automatic model_step(input logic a, input logic [31:0] d, input logic s,
                              input logic r, input logic [31:0] p);
        logic [31:0] tgt;
        tgt = {p[31:2], 2'b00};
        if (!m_req && !m_valid) begin
            if (r) m_pc = tgt;
            m_req = 1'b1;
            m_addr = m_pc;
        end else if (m_req) begin
            if (r) begin
                m_pc = tgt;
                if (a) begin m_drop = 1'b0; m_addr = tgt; end
                else m_drop = 1'b1;
            end else if (a) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_addr = m_pc;
                end else begin
                    m_instr = d; m_ipc = m_pc; m_valid = 1'b1; m_req = 1'b0;
                    m_pc = m_pc + 32'd4;
                end
            end
        end else begin
            if (r) begin
                m_pc = tgt; m_valid = 1'b0; m_req = 1'b1; m_addr = tgt;
            end else if (!s) begin
                m_valid = 1'b0; m_req = 1'b1; m_addr = m_pc;
`ifdef IF_FETCH_CNT_EN
                m_cnt = m_cnt + 32'd1;
`endif
            end
        end
    endtask

    vec_t tbl [0:27];

    initial begin
        logic [31:0] i0, i1;
        i0 = 32'h0000_0820;
        i1 = 32'h2008_0005;
        tbl[0]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0);
        tbl[1]  = mk(1'b1, i0,             1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   i0);
        tbl[2]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   32'h0);
        tbl[3]  = mk(1'b1, i0,             1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   i0);
        tbl[4]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0,   32'h0);
        tbl[5]  = mk(1'b1, i0,             1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   i0);
        tbl[6]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0,   32'h0);
        tbl[7]  = mk(1'b1, i0,             1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hC,   i0);
        tbl[8]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0,   32'h0);
        tbl[9]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0,   32'h0);
        tbl[10] = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0,   32'h0);
        tbl[11] = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0,   32'h0);
        tbl[12] = mk(1'b1, i1,             1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10,  i1);
        for (int k = 13; k <= 16; k++)
            tbl[k] = mk(1'b0, 32'h0,       1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10,  i1);
        tbl[17] = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 32'h0,   32'h0);
        tbl[18] = mk(1'b1, i0,             1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h14,  i0);
        tbl[19] = mk(1'b0, 32'h0,          1'b1, 1'b1, 32'h23,  1'b1, 32'h20,  1'b0, 32'h0,   32'h0);
        tbl[20] = mk(1'b0, 32'h0,          1'b0, 1'b1, 32'h103, 1'b1, 32'h20,  1'b0, 32'h0,   32'h0);
        tbl[21] = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h20,  1'b0, 32'h0,   32'h0);
        tbl[22] = mk(1'b1, 32'hDEAD_BEEF,  1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0);
        tbl[23] = mk(1'b1, 32'h0000_0822,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 32'h0000_0822);
        tbl[24] = mk(1'b0, 32'h0,          1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   32'h0);
        tbl[25] = mk(1'b1, 32'h1234_5678,  1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
        tbl[26] = mk(1'b0, 32'h0,          1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
        tbl[27] = mk(1'b1, 32'h8C00_0000,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 32'h8C00_0000);

        rst_n = 1'b0; ack = 1'b0; stall = 1'b0; redir = 1'b0; rdata = 32'h0; rpc = 32'h0;
        rst2_n = 1'b0; ack2 = 1'b0; stall2 = 1'b0; redir2 = 1'b0; rdata2 = 32'h0; rpc2 = 32'h0;
        #1;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", ipc, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 28; i++) begin
            ack = tbl[i].ack; rdata = tbl[i].rdata; stall = tbl[i].stall;
            redir = tbl[i].redir; rpc = tbl[i].rpc;
            tick();
            n_vec++;
            chk($sformatf("tbl%0d_req", i), {31'd0, req}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
                chk($sformatf("tbl%0d_ipc", i), ipc, tbl[i].e_ipc);
                chk($sformatf("tbl%0d_op", i), {26'd0, op}, {26'd0, tbl[i].e_instr[31:26]});
                chk($sformatf("tbl%0d_funct", i), {26'd0, funct}, {26'd0, tbl[i].e_instr[5:0]});
            end
        end
`ifdef IF_FETCH_CNT_EN
        chk("tbl_fetch_count", fcnt, 32'd6);
`endif
        ack = 1'b0; stall = 1'b0; redir = 1'b0;

        // Reset while an instruction is valid, then an ack arriving in reset/BOOT
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_req", {31'd0, req}, 32'd0);
        chk("midrst_instr", instr, 32'h0);
        ack = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        chk("boot_ack_req", {31'd0, req}, 32'd1);
        chk("boot_ack_addr", addr, 32'h0);
        chk("boot_ack_valid", {31'd0, valid}, 32'd0);
        ack = 1'b0;

        // Wrap instance: PC_RESET at the top of the address space
        tick();
        rst2_n = 1'b1;
        tick();
        n_vec++;
        chk("wrap_req0", {31'd0, req2}, 32'd1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        ack2 = 1'b1; rdata2 = 32'h0000_0820;
        tick();
        n_vec++;
        chk("wrap_valid", {31'd0, valid2}, 32'd1);
        chk("wrap_ipc", ipc2, 32'hFFFF_FFFC);
        chk("wrap_instr", instr2, 32'h0000_0820);
        chk("wrap_op", {26'd0, op2}, 32'd0);
        chk("wrap_funct", {26'd0, funct2}, 32'h20);
        ack2 = 1'b0;
        tick();
        n_vec++;
        chk("wrap_req1", {31'd0, req2}, 32'd1);
        chk("wrap_addr1", addr2, 32'h0000_0000);
        rst2_n = 1'b0;
        #1;
        n_vec++;
        chk("wrap_rst_req", {31'd0, req2}, 32'd0);
        chk("wrap_rst_valid", {31'd0, valid2}, 32'd0);
        ack2 = 1'b1; rdata2 = 32'h1111_2222;
        tick();
        chk("wrap_late_ack_valid", {31'd0, valid2}, 32'd0);
        rst2_n = 1'b1;
        tick();
        n_vec++;
        chk("wrap_reboot_req", {31'd0, req2}, 32'd1);
        chk("wrap_reboot_addr", addr2, 32'hFFFF_FFFC);
        chk("wrap_reboot_valid", {31'd0, valid2}, 32'd0);
        ack2 = 1'b0;

        // Random stimulus against the model
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            ack   = ($urandom_range(0, 2) == 0);
            stall = ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 9) == 0);
            rdata = $urandom;
            rpc   = $urandom;
            model_step(ack, rdata, stall, redir, rpc);
            tick();
            n_vec++;
            chk("rnd_req", {31'd0, req}, {31'd0, m_req});
            chk("rnd_valid", {31'd0, valid}, {31'd0, m_valid});
            if (m_req) chk("rnd_addr", addr, m_addr);
            if (m_valid) begin
                chk("rnd_instr", instr, m_instr);
                chk("rnd_ipc", ipc, m_ipc);
                chk("rnd_op", {26'd0, op}, {26'd0, m_instr[31:26]});
                chk("rnd_funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
            end
`ifdef IF_FETCH_CNT_EN
            chk("rnd_fetch_count", fcnt, m_cnt);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
